// File: rtl/img_pkg.sv
//------------------------------------------------------------------------------
// Module   : img_pkg
// Brief    : Shared pixel-format constants and types for the image pipeline.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package img_pkg;

    localparam int PIX_W          = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
//------------------------------------------------------------------------------
// Module   : line_buffer
// Brief    : One line of pixel storage, synchronous write, asynchronous read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    // Combinational read returns the pre-write contents on a same-address write.
    assign dout = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
//------------------------------------------------------------------------------
// Module   : window_3x3_gen
// Brief    : Streaming 3x3 raster neighbourhood generator (two line buffers).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module window_3x3_gen #(
    parameter int IMG_WIDTH  = img_pkg::IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = img_pkg::IMG_HEIGHT_DEF,
    parameter int PIX_W      = img_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] x_0,
    output logic [PIX_W-1:0] x_1,
    output logic [PIX_W-1:0] x_2,
    output logic [PIX_W-1:0] x_3,
    output logic [PIX_W-1:0] x_4,
    output logic [PIX_W-1:0] x_5,
    output logic [PIX_W-1:0] x_6,
    output logic [PIX_W-1:0] x_7,
    output logic [PIX_W-1:0] x_8,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_col_two  = CW'(2);
    localparam logic [RW-1:0] c_row_two  = RW'(2);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_win [9];
    logic             r_win_valid;
    logic             r_frame_done;

    logic             w_accept;
    logic [PIX_W-1:0] w_a;
    logic [PIX_W-1:0] w_b;

    // A pixel coincident with reset is dropped, including its line-buffer write.
    assign w_accept = in_valid && !rst;

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk  (clk),
        .we   (w_accept),
        .addr (r_col),
        .din  (in_pixel),
        .dout (w_a)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk  (clk),
        .we   (w_accept),
        .addr (r_col),
        .din  (w_a),
        .dout (w_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_win_valid  <= in_valid && (r_row >= c_row_two) && (r_col >= c_col_two);
            r_frame_done <= in_valid && (r_row == c_row_last) && (r_col == c_col_last);
            if (in_valid) begin
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_b;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_a;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= in_pixel;
            end
        end
    end

    assign x_0        = r_win[0];
    assign x_1        = r_win[1];
    assign x_2        = r_win[2];
    assign x_3        = r_win[3];
    assign x_4        = r_win[4];
    assign x_5        = r_win[5];
    assign x_6        = r_win[6];
    assign x_7        = r_win[7];
    assign x_8        = r_win[8];
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_window_3x3_gen
// Brief    : Scoreboard bench for window_3x3_gen on a 4x4 frame.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] win;
        logic        done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
    logic [7:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8;
    logic       win_valid;
    logic       frame_done;

    exp_t        sb[$];
    logic [71:0] obs[$];
    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;
    logic        last_acc = 1'b0;

    always #5 clk = ~clk;

    window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .x_0        (x_0),
        .x_1        (x_1),
        .x_2        (x_2),
        .x_3        (x_3),
        .x_4        (x_4),
        .x_5        (x_5),
        .x_6        (x_6),
        .x_7        (x_7),
        .x_8        (x_8),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    function automatic logic [71:0] cur_win();
        return {x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8};
    endfunction

    function automatic logic [71:0] model_win(input logic [7:0] base, input int r, input int c);
        logic [71:0] w = '0;
        for (int k = 0; k < 9; k++) begin
            w = {w[63:0], 8'(base + 16 * (r - 2 + k / 3) + (c - 2 + k % 3))};
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Acceptance seen by the DUT at each edge, for the idle-cycle rule.
    always @(posedge clk) last_acc <= in_valid && !rst;

    always @(negedge clk) begin
        if (win_valid) begin
            exp_t e;
            check("valid_after_idle", 72'(last_acc), 72'd1);
            obs.push_back(cur_win());
            if (frame_done) n_done++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window got %h expected none", cur_win());
            end else begin
                e = sb.pop_front();
                check("window", cur_win(), e.win);
                check("frame_done", 72'(frame_done), 72'(e.done));
            end
        end else begin
            check("done_without_window", 72'(frame_done), 72'd0);
        end
    end

    task automatic drive_pix(input logic [7:0] base, input int r, input int c);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_pixel = 8'(base + 16 * r + c);
        if (r >= 2 && c >= 2) begin
            sb.push_back('{win: model_win(base, r, c), done: (r == H - 1 && c == W - 1)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) idle(int'($urandom_range(0, 1)));
                drive_pix(base, r, c);
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        check({name, "_x"}, cur_win(), 72'h0);
        check({name, "_valid"}, 72'(win_valid), 72'd0);
        check({name, "_done"}, 72'(frame_done), 72'd0);
    endtask

    task automatic pulse_reset(input logic with_pixel);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = with_pixel;
        in_pixel = 8'hEE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        pulse_reset(1'b0);
        check_reset_state("reset");

        // Continuous frame
        obs.delete();
        d0 = n_done;
        send_frame(8'h00, 1'b0);
        idle(3);
        check("f1_count", 72'(obs.size()), 72'd4);
        check("f1_first", obs[0], 72'h000102_101112_202122);
        check("f1_last_x0", 72'(obs[3][71:64]), 72'h11);
        check("f1_last_x8", 72'(obs[3][7:0]), 72'h33);
        check("f1_done_count", 72'(n_done - d0), 72'd1);

        // Random gaps
        obs.delete();
        send_frame(8'h00, 1'b1);
        idle(3);
        check("gap_count", 72'(obs.size()), 72'd4);
        check("gap_first", obs[0], 72'h000102_101112_202122);
        check("gap_last", obs[3], 72'h111213_212223_313233);

        // Back-to-back frames
        obs.delete();
        d0 = n_done;
        send_frame(8'h00, 1'b0);
        send_frame(8'h80, 1'b0);
        idle(3);
        check("b2b_count", 72'(obs.size()), 72'd8);
        check("b2b_f2_first", obs[4], 72'h808182_909192_A0A1A2);
        check("b2b_done_count", 72'(n_done - d0), 72'd2);

        // Reset after pixel (2,1)
        for (int k = 0; k < 10; k++) drive_pix(8'h40, k / W, k % W);
        pulse_reset(1'b0);
        check_reset_state("midreset");
        obs.delete();
        send_frame(8'h00, 1'b0);
        idle(3);
        check("midreset_count", 72'(obs.size()), 72'd4);
        check("midreset_first", obs[0], 72'h000102_101112_202122);

        // Reset coincident with in_valid: pixel dropped, counters stay at (0,0)
        pulse_reset(1'b1);
        check_reset_state("rstvalid");
        obs.delete();
        send_frame(8'h00, 1'b0);
        idle(3);
        check("rstvalid_count", 72'(obs.size()), 72'd4);
        check("rstvalid_first", obs[0], 72'h000102_101112_202122);

        check("sb_empty", 72'(sb.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator for 8-bit raster pixels. It sits directly upstream of the 9-input median sorting pipeline, and its `x_0..x_8` outputs connect to that pipeline's inputs one for one. Each accepted raster pixel becomes the bottom-right corner of a 3x3 window, buffered through two line buffers plus a 3-column shift window. Windows are flagged valid only when they lie fully inside the frame.

## Interface
Parameters:
- `IMG_WIDTH`, default 640: pixels per line; legal range is 3 or more.
- `IMG_HEIGHT`, default 480: lines per frame; legal range is 3 or more.
- `PIX_W`, default 8: pixel width in bits.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: `in_pixel` is presented this cycle and is accepted unconditionally (no backpressure).
- `in_pixel`  in  PIX_W: raster-order pixel, left to right, top to bottom.
- `x_0`..`x_8`  out  PIX_W each: window, row-major. `x_0` is top-left (row r-2, col c-2); `x_8` is bottom-right (row r, col c).
- `win_valid`  out  1: window is complete and lies inside the frame.
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Internal column counter `col` (0..IMG_WIDTH-1) and row counter `row` (0..IMG_HEIGHT-1).
  - Counter width is `$clog2` of the dimension.
  - Both advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last line.
- Line buffer `lb0` holds line r-1; `lb1` holds line r-2. Both are addressed by `col`.
- Per accepted pixel at (row, col):
  - Read `a = lb0[col]` and `b = lb1[col]` (old contents).
  - Write `lb0[col] <= in_pixel` and `lb1[col] <= a`.
  - Window shifts one column left: `x_0<=x_1`, `x_1<=x_2`, `x_3<=x_4`, `x_4<=x_5`, `x_6<=x_7`, `x_7<=x_8`.
  - New right column: `x_2<=b`, `x_5<=a`, `x_8<=in_pixel`.
- `win_valid <= in_valid && row>=2 && col>=2`. Windows at col 0/1 mix data from the previous line and are suppressed. Rows 0/1 are never valid, so stale line-buffer data from a previous frame or from before reset is never exposed.
- `frame_done <= in_valid && row==IMG_HEIGHT-1 && col==IMG_WIDTH-1`.
- `in_valid` low: counters, line buffers and window registers hold; `win_valid` and `frame_done` are 0 next cycle.
- Valid windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- No explicit start-of-frame input. Frame alignment comes from counters only, so the source must deliver whole frames after reset.

## Timing
- Latency 1: the window for pixel (r,c) and its `win_valid` appear the cycle after that pixel is accepted.
- Back-to-back `in_valid` yields one window per cycle. Frames may be back-to-back with no gap: pixel (0,0) of frame N+1 may be accepted in the cycle after pixel (H-1,W-1) of frame N.
- Reset, cycle after `rst` high:
  - `row=0`, `col=0`, `win_valid=0`, `frame_done=0`, `x_0..x_8=0`.
  - Line-buffer RAM contents are not reset.
- `rst` wins over a simultaneous `in_valid`; that pixel is dropped.
- Reset mid-frame abandons the partial frame. The next accepted pixel is (0,0).
- Line-buffer read is combinational and returns old data on same-address read and write (read-before-write).

## Structure
- Shared package `img_pkg`: `PIX_W` and default `IMG_WIDTH`/`IMG_HEIGHT` constants, plus the `pixel_t` typedef (logic [PIX_W-1:0]). The median pipeline uses the same package.
- Sub-module `line_buffer`, instantiated twice:
  - Parameters: depth IMG_WIDTH, width PIX_W.
  - Ports: `clk`, `we`, `addr`, `din`, `dout`.
  - Synchronous write, asynchronous read, no reset.
- Top level holds the counters, the window registers and the valid/done logic.

## Test plan
Use IMG_WIDTH=4 and IMG_HEIGHT=4 with pixel value = 16*row+col.
- Continuous frame:
  - First `win_valid` comes the cycle after pixel (2,2) is accepted, with `x_0..x_8` = 0x00,01,02,10,11,12,20,21,22.
  - Exactly 4 valid windows; the last one has `x_8`=0x33 and `x_0`=0x11.
  - `frame_done` pulses once, coincident with that last window.
- Random `in_valid` gaps (about 50% duty): the same 4 windows appear in the same order with identical contents, and `win_valid` is never high in a cycle following an idle cycle.
- Two back-to-back frames, the second with values +0x80: frame 2's first window is 0x80,81,82,90,91,92,A0,A1,A2 with no frame-1 data, and 8 windows in total.
- Reset asserted after pixel (2,1):
  - Next cycle: outputs are 0 and `win_valid`=0.
  - Then send a fresh frame: 4 correct windows; no valid output before (2,2) of the new frame.
- Reset coincident with `in_valid`: the pixel is dropped and the counter stays at (0,0).
- Default parameters, random frame streamed into the median pipeline: the median output matches a software 3x3 median over interior pixels, in order.
